alu_operand_stage: RTL and testbench
====================================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter: TAG_W, default 5, width of the destination-tag sideband carried with each operation.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 flush  input  1  synchronous discard of all held operations.
REQ-005 in_valid  input  1  upstream operation present.
REQ-006 in_ready  output  1  stage accepts an operation this cycle.
REQ-007 in_op  input  3  operation code: ADD=0, SUB=1, SLT=2, SLTU=3; 4..7 illegal.
REQ-008 in_rs1, in_rs2  input  32 each  raw source operands.
REQ-009 in_tag  input  TAG_W  sideband carried unchanged.
REQ-010 out_valid  output  1  adder operands present.
REQ-011 out_ready  input  1  adder stage consumes this cycle.
REQ-012 add_a, add_b  output  32 each  adder operands (add_b inverted for subtract-class ops).
REQ-013 add_cin, add_sub, add_a_sign, add_b_sign  output  1 each  adder control and true operand signs.
REQ-014 out_op  output  3, out_tag  output  TAG_W, out_illegal  output  1  forwarded op, tag, illegal-op flag.

Function
REQ-015 Transfer occurs on a side only when valid and ready are both 1 at a rising edge; out_valid, once 1, SHALL stay 1 with stable payload until out_ready=1.
REQ-016 Latency SHALL be exactly one cycle from input handshake to out_valid=1 when the stage was empty.
REQ-017 ADD: add_a=rs1, add_b=rs2, add_cin=0, add_sub=0, add_a_sign=rs1[31], add_b_sign=rs2[31].
REQ-018 SUB and SLT: add_b=~rs2, add_cin=1, add_sub=1, signs as REQ-017 (true signs of rs1, rs2, not of ~rs2).
REQ-019 SLTU: as SUB except add_a_sign=0 and add_b_sign=0.
REQ-020 Illegal op (4..7): payload as ADD, out_illegal=1, out_op forwarded unchanged; otherwise out_illegal=0.
REQ-021 Operand preparation SHALL be computed before the register; outputs SHALL be driven directly from flops.
REQ-022 flush=1: all held entries invalidated at the edge; out_valid=0 next cycle; in_ready SHALL be 0 during the flush cycle so no beat is accepted.
REQ-023 Simultaneous output consume and input accept SHALL sustain one operation per cycle with no bubble.

Reset
REQ-024 rst_n=0 at an edge: all valid flags 0; out_valid=0; add_a, add_b, out_tag, out_op, all 1-bit payload outputs 0; in_ready=0 during reset, 1 the first cycle after release.
REQ-025 Reset asserted mid-transfer SHALL drop all held operations; reset dominates flush.

Configuration
REQ-026 Macro ALU_OPERAND_SKID_EN defined: two-entry skid buffer (main + skid register); in_ready SHALL be a flop output equal to !skid_valid; a beat accepted while main is full and out_ready=0 goes to skid; skid moves to main when main is consumed; order preserved.
REQ-027 Macro undefined: single register; in_ready = !out_valid || out_ready (combinational, still forced 0 on flush/reset); no skid storage.

Structure
REQ-028 Shared package alu_pkg SHALL hold the op-code enum (ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU), data width 32, and a packed struct for the adder-operand payload.
REQ-029 One sub-module alu_operand_prep (combinational op -> payload decode) SHALL be instantiated once; the stage itself holds only registers and handshake.

Verification
REQ-030 SUB rs1=5, rs2=3, out_ready=1 -> next cycle out_valid=1, add_b=32'hFFFF_FFFC, add_cin=1, add_sub=1, signs 0/0.
REQ-031 SLTU rs1=32'h8000_0000, rs2=1 -> add_a_sign=0, add_b_sign=0, add_b=32'hFFFF_FFFE; SLT same operands -> add_a_sign=1.
REQ-032 Back-to-back 8 ADDs tags 0..7, out_ready=1 -> 8 outputs on 8 consecutive cycles, tags in order.
REQ-033 out_ready held 0 for 3 cycles while in_valid=1 -> with ALU_OPERAND_SKID_EN exactly 2 accepted, in_ready=0 thereafter; without it exactly 1 accepted; no loss or reorder on release.
REQ-034 flush=1 with two entries held and in_valid=1 -> in_ready=0 that cycle, out_valid=0 next cycle, no flushed tag ever appears.
REQ-035 op=6 rs1=1 rs2=2 -> out_illegal=1, add_b=2, add_cin=0; rst_n=0 mid-stall -> out_valid=0 next cycle, all payload 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand stage: op-code enum, data width and
// the packed adder-operand payload produced by operand preparation.
package alu_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_SLT  = 3'd2,
        ALU_SLTU = 3'd3
    } alu_op_e;

    // op is kept as raw bits so illegal codes 4..7 are forwarded unchanged.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              cin;
        logic              sub;
        logic              a_sign;
        logic              b_sign;
        logic              illegal;
        logic [2:0]        op;
    } adder_opnd_t;

endpackage

// File: rtl/alu_operand_prep.sv
// Combinational decode of op code and raw sources into the adder-operand
// payload; the stage registers its output.
module alu_operand_prep
    import alu_pkg::*;
(
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] rs1_i,
    input  logic [DATA_W-1:0] rs2_i,
    output adder_opnd_t       opnd_o
);

    always_comb begin
        opnd_o.a       = rs1_i;
        opnd_o.b       = rs2_i;
        opnd_o.cin     = 1'b0;
        opnd_o.sub     = 1'b0;
        opnd_o.a_sign  = rs1_i[DATA_W-1];
        opnd_o.b_sign  = rs2_i[DATA_W-1];
        opnd_o.illegal = 1'b0;
        opnd_o.op      = op_i;
        case (op_i)
            ALU_ADD: begin
                opnd_o.illegal = 1'b0;
            end
            ALU_SUB, ALU_SLT: begin
                opnd_o.b   = ~rs2_i;
                opnd_o.cin = 1'b1;
                opnd_o.sub = 1'b1;
            end
            ALU_SLTU: begin
                // Unsigned compare: operands carry no sign.
                opnd_o.b      = ~rs2_i;
                opnd_o.cin    = 1'b1;
                opnd_o.sub    = 1'b1;
                opnd_o.a_sign = 1'b0;
                opnd_o.b_sign = 1'b0;
            end
            default: begin
                opnd_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered operand stage in front of the adder with valid/ready handshake.
// Define ALU_OPERAND_SKID_EN for a two-entry skid buffer with registered in_ready.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_rs1,
    input  logic [DATA_W-1:0] in_rs2,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    output logic              add_cin,
    output logic              add_sub,
    output logic              add_a_sign,
    output logic              add_b_sign,
    output logic [2:0]        out_op,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_illegal
);

    adder_opnd_t prep;

    alu_operand_prep u_prep (
        .op_i   (in_op),
        .rs1_i  (in_rs1),
        .rs2_i  (in_rs2),
        .opnd_o (prep)
    );

    logic              accept;
    logic              consume;
    logic              main_valid_q, main_valid_d;
    adder_opnd_t       main_q, main_d;
    logic [TAG_W-1:0]  main_tag_q, main_tag_d;

    assign accept  = in_valid && in_ready;
    assign consume = main_valid_q && out_ready;

`ifdef ALU_OPERAND_SKID_EN
    logic              ready_q, ready_d;
    logic              skid_valid_q, skid_valid_d;
    adder_opnd_t       skid_q, skid_d;
    logic [TAG_W-1:0]  skid_tag_q, skid_tag_d;

    assign in_ready = ready_q && rst_n && !flush;

    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        main_tag_d   = main_tag_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        skid_tag_d   = skid_tag_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (consume) begin
                main_valid_d = skid_valid_q;
                main_d       = skid_q;
                main_tag_d   = skid_tag_q;
                skid_valid_d = 1'b0;
            end
            // A beat is only accepted while skid is empty, so it lands in
            // main when main frees up this cycle, otherwise in skid.
            if (accept) begin
                if (!main_valid_d) begin
                    main_valid_d = 1'b1;
                    main_d       = prep;
                    main_tag_d   = in_tag;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_d       = prep;
                    skid_tag_d   = in_tag;
                end
            end
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q      <= 1'b1;
            main_valid_q <= 1'b0;
            main_q       <= '0;
            main_tag_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_tag_q   <= '0;
        end else begin
            ready_q      <= ready_d;
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
            main_tag_q   <= main_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            skid_tag_q   <= skid_tag_d;
        end
    end
`else
    assign in_ready = rst_n && !flush && (!main_valid_q || out_ready);

    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        main_tag_d   = main_tag_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (accept) begin
            main_valid_d = 1'b1;
            main_d       = prep;
            main_tag_d   = in_tag;
        end else if (consume) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
            main_tag_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
            main_tag_q   <= main_tag_d;
        end
    end
`endif

    assign out_valid   = main_valid_q;
    assign add_a       = main_q.a;
    assign add_b       = main_q.b;
    assign add_cin     = main_q.cin;
    assign add_sub     = main_q.sub;
    assign add_a_sign  = main_q.a_sign;
    assign add_b_sign  = main_q.b_sign;
    assign out_illegal = main_q.illegal;
    assign out_op      = main_q.op;
    assign out_tag     = main_tag_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed beats push hand-computed
// expectations; a negedge monitor pops and compares on every output transfer.
module tb_alu_operand_stage;

    localparam int TAG_W = 5;
`ifdef ALU_OPERAND_SKID_EN
    localparam int EXP_ACC = 2;
`else
    localparam int EXP_ACC = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_op = 3'd0;
    logic [31:0]       in_rs1 = 32'd0;
    logic [31:0]       in_rs2 = 32'd0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       add_a, add_b;
    logic              add_cin, add_sub, add_a_sign, add_b_sign;
    logic [2:0]        out_op;
    logic [TAG_W-1:0]  out_tag;
    logic              out_illegal;

    alu_operand_stage #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_cin     (add_cin),
        .add_sub     (add_sub),
        .add_a_sign  (add_a_sign),
        .add_b_sign  (add_b_sign),
        .out_op      (out_op),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic             sub;
        logic             as;
        logic             bs;
        logic             ill;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned out_cyc[$];
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [76:0] pay_now();
        return {add_a, add_b, add_cin, add_sub, add_a_sign, add_b_sign, out_illegal, out_op,
                out_tag};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: transfer-time compare plus payload stability under backpressure.
    initial begin
        exp_t        e;
        logic        hold_prev = 1'b0;
        logic [76:0] hold_snap = '0;
        logic [76:0] want;
        forever begin
            @(negedge clk);
            if (rst_n && !flush) begin
                if (hold_prev) begin
                    checks++;
                    if (!out_valid || pay_now() !== hold_snap) begin
                        errors++;
                        $display("FAIL stall_stable: got v=%b %h required v=1 %h", out_valid,
                                 pay_now(), hold_snap);
                    end
                end
                if (out_valid && out_ready) begin
                    out_cyc.push_back(cyc);
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got tag %0d required no output",
                                 out_tag);
                    end else begin
                        e = sb.pop_front();
                        want = {e.a, e.b, e.sub, e.sub, e.as, e.bs, e.ill, e.op, e.tag};
                        if (pay_now() !== want) begin
                            errors++;
                            $display("FAIL output_payload: got %h required %h", pay_now(), want);
                        end
                    end
                end
                hold_prev = out_valid && !out_ready;
                hold_snap = pay_now();
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] eb,
                            input logic [TAG_W-1:0] tag, input logic esub, input logic eas,
                            input logic ebs, input logic eill);
        exp_t e;
        e.a = rs1; e.b = eb; e.sub = esub; e.as = eas; e.bs = ebs; e.ill = eill;
        e.op = op; e.tag = tag;
        sb.push_back(e);
    endtask

    // Presents a beat and waits (bounded) for its handshake; leaves in_valid high.
    task automatic send(input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [TAG_W-1:0] tag, input logic [31:0] eb, input logic esub,
                        input logic eas, input logic ebs, input logic eill);
        bit ok = 1'b0;
        in_valid = 1'b1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_tag = tag;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(op, rs1, eb, tag, esub, eas, ebs, eill);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++; checks++;
            $display("FAIL send_timeout: got no in_ready for tag %0d required handshake", tag);
        end
        step();
    endtask

    initial begin
        int accepted;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'(0));
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_add_a", 64'(add_a), 64'(0));
        chk("reset_add_b", 64'(add_b), 64'(0));
        chk("reset_ctrl", 64'({add_cin, add_sub, add_a_sign, add_b_sign, out_illegal, out_op,
                               out_tag}), 64'(0));
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 64'(in_ready), 64'(1));
        step();

        // SUB 5-3 with one-cycle latency
        out_ready = 1'b1;
        send(3'd1, 32'd5, 32'd3, 5'd1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("sub_latency_valid", 64'(out_valid), 64'(1));
        chk("sub_add_b", 64'(add_b), 64'hFFFF_FFFC);
        chk("sub_ctrl", 64'({add_cin, add_sub, add_a_sign, add_b_sign}), 64'(4'b1100));
        step();

        // SLTU vs SLT signs
        send(3'd3, 32'h8000_0000, 32'd1, 5'd2, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("sltu_signs", 64'({add_a_sign, add_b_sign}), 64'(0));
        chk("sltu_add_b", 64'(add_b), 64'hFFFF_FFFE);
        step();
        send(3'd2, 32'h8000_0000, 32'd1, 5'd3, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("slt_a_sign", 64'(add_a_sign), 64'(1));
        step();

        // ADD with negative rs2, and an illegal op
        send(3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 5'd4, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        send(3'd6, 32'd1, 32'd2, 5'd3, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("illegal_flag", 64'(out_illegal), 64'(1));
        chk("illegal_add_b", 64'(add_b), 64'(2));
        chk("illegal_cin", 64'(add_cin), 64'(0));
        repeat (3) step();

        // Back-to-back 8 ADDs
        out_cyc.delete();
        for (int t = 0; t < 8; t++) begin
            send(3'd0, 32'd100 + 32'(t), 32'(t * 3), 5'(t), 32'(t * 3), 1'b0, 1'b0, 1'b0,
                 1'b0);
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk("burst_count", 64'(out_cyc.size()), 64'(8));
        if (out_cyc.size() == 8) chk("burst_consecutive", 64'(out_cyc[7] - out_cyc[0]), 64'(7));

        // Backpressure: out_ready low for 3 cycles with in_valid held
        out_ready = 1'b0;
        accepted = 0;
        in_valid = 1'b1; in_op = 3'd0; in_tag = 5'd10;
        in_rs1 = 32'h1000 + 32'(in_tag); in_rs2 = 32'(in_tag);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(3'd0, in_rs1, in_rs2, in_tag, 1'b0, 1'b0, 1'b0, 1'b0);
                accepted++;
            end
            step();
            in_tag = 5'(10 + accepted);
            in_rs1 = 32'h1000 + 32'(in_tag); in_rs2 = 32'(in_tag);
        end
        @(negedge clk);
        chk("stall_in_ready", 64'(in_ready), 64'(0));
        chk("stall_accepted", 64'(accepted), 64'(EXP_ACC));
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        chk("stall_drain", 64'(sb.size()), 64'(0));

        // Flush with entries held and a beat offered
        out_ready = 1'b0;
        accepted = 0;
        in_valid = 1'b1; in_op = 3'd1; in_rs1 = 32'd7; in_rs2 = 32'd9; in_tag = 5'd20;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (in_ready) accepted++;
            step();
            in_tag = 5'(20 + accepted);
        end
        in_tag = 5'd22;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'(0));
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        step();
        out_ready = 1'b1;
        repeat (4) step();

        // Reset mid-stall, asserted together with flush
        out_ready = 1'b0;
        send(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        flush = 1'b1;
        in_tag = 5'd6;
        @(negedge clk);
        chk("midreset_in_ready", 64'(in_ready), 64'(0));
        step();
        sb.delete();
        rst_n = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midreset_out_valid", 64'(out_valid), 64'(0));
        chk("midreset_add_a", 64'(add_a), 64'(0));
        chk("midreset_add_b", 64'(add_b), 64'(0));
        chk("midreset_ctrl", 64'({add_cin, add_sub, add_a_sign, add_b_sign, out_illegal, out_op,
                                  out_tag}), 64'(0));
        chk("midreset_in_ready_rel", 64'(in_ready), 64'(1));
        step();

        // Stage still operational afterwards
        out_ready = 1'b1;
        send(3'd1, 32'd0, 32'd0, 5'd9, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        repeat (2) step();
        chk("final_drain", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
